// File: rtl/int_ctrl.sv
// int_ctrl
//
// Interrupt controller for the multi-cycle CPU. It latches rising edges on
// five peripheral lines into a pending register and masks them. It then
// presents the highest-priority source (bit 0 first) on Ireq/gntInt,
// completes the Iack handshake, and holds the in-service source until
// software writes EOI. The controller is non-nested.
//
// State table:
//   state   | meaning
//   IDLE    | no request outstanding, waiting for a masked-in pending source
//   REQ     | Ireq high, grant frozen, waiting for Iack (or withdraw)
//   SERVICE | CPU servicing grant, waiting for an EOI write
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-low reset
//   irq_in  in   [N_SRC-1:0] peripheral interrupt lines (rising edge = event)
//   Ireq    out  interrupt request to the CPU
//   gntInt  out  [N_SRC-1:0] one-hot granted source (REQ/SERVICE), else 0
//   Iack    in   CPU acknowledge
//   stb     in   register-port strobe, held until ack
//   we      in   write enable
//   addr    in   [1:0] register select (0 MASK, 1 PEND W1C, 2 GRANT, 3 EOI)
//   dat_i   in   [31:0] write data
//   dat_o   out  [31:0] registered read data, valid with ack
//   ack     out  single-cycle transfer acknowledge

module int_ctrl #(
    parameter int N_SRC = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    output logic             Ireq,
    output logic [N_SRC-1:0] gntInt,
    input  logic             Iack,
    input  logic             stb,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    output logic             ack
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] A_MASK  = 2'd0;
    localparam logic [1:0] A_PEND  = 2'd1;
    localparam logic [1:0] A_GRANT = 2'd2;
    localparam logic [1:0] A_EOI   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic             accept;
    logic             wr_mask, wr_pend, wr_eoi;
    logic [N_SRC-1:0] cand;
    logic [N_SRC-1:0] cand_1h;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [31:0]      rdata;

    // Ack is forced low in the cycle after an ack, so a held strobe is
    // accepted at most once every two cycles.
    assign accept  = stb && !ack_q;
    assign wr_mask = accept && we && (addr == A_MASK);
    assign wr_pend = accept && we && (addr == A_PEND);
    assign wr_eoi  = accept && we && (addr == A_EOI);

    assign rise    = irq_in & ~irq_q;
    assign cand    = pend_q & mask_q;
    // Isolate the lowest set bit (two's complement trick).
    assign cand_1h = cand & (~cand + 1'b1);

    assign Ireq   = (state_q == ST_REQ);
    assign gntInt = (state_q == ST_IDLE) ? '0 : grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        clr     = '0;
        if (wr_pend) begin
            clr = dat_i[N_SRC-1:0];
        end
        case (state_q)
            ST_IDLE: begin
                if (cand != '0) begin
                    grant_d = cand_1h;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (Iack) begin
                    clr     = clr | grant_q;
                    state_d = ST_SERVICE;
                end else if ((grant_q & pend_q & mask_q) == '0) begin
                    // Source was W1C-cleared or masked while pending.
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        // A new edge wins over a clear of the same bit.
        pend_d = (pend_q & ~clr) | rise;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_MASK:  rdata[N_SRC-1:0] = mask_q;
            A_PEND:  rdata[N_SRC-1:0] = pend_q;
            A_GRANT: rdata[N_SRC-1:0] = gntInt;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        mask_d = mask_q;
        ack_d  = accept;
        dat_d  = dat_q;
        if (wr_mask) begin
            mask_d = dat_i[N_SRC-1:0];
        end
        if (accept) begin
            dat_d = we ? '0 : rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            irq_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            grant_q <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_in;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign ack   = ack_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl. Inputs are driven and outputs sampled
// on the falling edge; the "cycle" of a negedge is the clock period that
// ends at the following rising edge.

module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  irq_in;
    logic        Ireq;
    logic [4:0]  gntInt;
    logic        Iack;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    int passed = 0;
    int total  = 0;

    int_ctrl #(.N_SRC(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .Ireq   (Ireq),
        .gntInt (gntInt),
        .Iack   (Iack),
        .stb    (stb),
        .we     (we),
        .addr   (addr),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .ack    (ack)
    );

    always #5 clk = ~clk;

    // One bus transfer: strobe in cycle s, sample ack/dat_o in s+1.
    // Returns at the negedge of cycle s+1 with stb dropped.
    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic got_ack, output logic [31:0] rd);
        @(negedge clk);
        stb = 1'b1; we = w; addr = a; dat_i = d;
        @(negedge clk);
        got_ack = ack;
        rd      = dat_o;
        stb = 1'b0; we = 1'b0; dat_i = '0;
    endtask

    // Edge in cycle t; returns at the negedge of cycle t+1.
    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        irq_in = m;
        @(negedge clk);
        irq_in = '0;
    endtask

    // Iack high for cycle u; returns at the negedge of u+1.
    task automatic do_iack();
        Iack = 1'b1;
        @(negedge clk);
        Iack = 1'b0;
    endtask

    task automatic test_reset();
        logic a; logic [31:0] r;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        total++; if ({Ireq, gntInt, ack} !== 7'b0) $display("FAIL reset_outs got %b exp 0", {Ireq, gntInt, ack}); else passed++;
        total++; if (dat_o !== 32'h0) $display("FAIL reset_dat_o got %h exp 0", dat_o); else passed++;
        bus(1'b0, 2'd0, 32'h0, a, r);
        total++; if ({a, r} !== {1'b1, 32'h0}) $display("FAIL reset_mask ack=%b got %h exp ack=1 0", a, r); else passed++;
    endtask

    task automatic test_basic();
        logic a; logic [31:0] r;
        bus(1'b1, 2'd0, 32'h1F, a, r);
        pulse(5'b00100);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_00100) $display("FAIL basic_req got %b exp 100100", {Ireq, gntInt}); else passed++;
        do_iack();
        total++; if ({Ireq, gntInt} !== 6'b0_00100) $display("FAIL basic_service got %b exp 000100", {Ireq, gntInt}); else passed++;
        bus(1'b0, 2'd1, 32'h0, a, r);
        total++; if (r !== 32'h0) $display("FAIL basic_pend got %h exp 0", r); else passed++;
        bus(1'b0, 2'd2, 32'h0, a, r);
        total++; if (r !== 32'h4) $display("FAIL basic_grant got %h exp 4", r); else passed++;
        bus(1'b1, 2'd3, 32'h0, a, r);
        total++; if ({Ireq, gntInt} !== 6'b0) $display("FAIL basic_eoi got %b exp 0", {Ireq, gntInt}); else passed++;
    endtask

    task automatic test_priority();
        logic a; logic [31:0] r;
        pulse(5'b10010);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_00010) $display("FAIL prio_first got %b exp 100010", {Ireq, gntInt}); else passed++;
        do_iack();
        bus(1'b1, 2'd3, 32'h0, a, r);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_10000) $display("FAIL prio_second got %b exp 110000", {Ireq, gntInt}); else passed++;
        do_iack();
        bus(1'b1, 2'd3, 32'h0, a, r);
    endtask

    task automatic test_masking();
        logic a; logic [31:0] r;
        bus(1'b1, 2'd0, 32'h0, a, r);
        pulse(5'b00001);
        repeat (2) @(negedge clk);
        total++; if (Ireq !== 1'b0) $display("FAIL mask_blocked got %b exp 0", Ireq); else passed++;
        bus(1'b0, 2'd1, 32'h0, a, r);
        total++; if (r !== 32'h1) $display("FAIL mask_pend got %h exp 1", r); else passed++;
        bus(1'b1, 2'd0, 32'h1, a, r);
        total++; if (Ireq !== 1'b0) $display("FAIL mask_s1 got %b exp 0", Ireq); else passed++;
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_00001) $display("FAIL mask_enable got %b exp 100001", {Ireq, gntInt}); else passed++;
        do_iack();
        bus(1'b1, 2'd3, 32'h0, a, r);
        bus(1'b1, 2'd0, 32'h1F, a, r);
    endtask

    task automatic test_withdraw();
        logic a; logic [31:0] r;
        pulse(5'b01000);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_01000) $display("FAIL wd_req got %b exp 101000", {Ireq, gntInt}); else passed++;
        bus(1'b1, 2'd1, 32'h8, a, r);
        total++; if (Ireq !== 1'b1) $display("FAIL wd_s1 got %b exp 1", Ireq); else passed++;
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b0) $display("FAIL wd_s2 got %b exp 0", {Ireq, gntInt}); else passed++;
        bus(1'b0, 2'd2, 32'h0, a, r);
        total++; if (r !== 32'h0) $display("FAIL wd_grant got %h exp 0", r); else passed++;
    endtask

    task automatic test_nonnested();
        logic a; logic [31:0] r;
        pulse(5'b00001);
        @(negedge clk);
        do_iack();
        pulse(5'b00011);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b0_00001) $display("FAIL nn_hold got %b exp 000001", {Ireq, gntInt}); else passed++;
        bus(1'b0, 2'd1, 32'h0, a, r);
        total++; if (r !== 32'h3) $display("FAIL nn_pend got %h exp 3", r); else passed++;
        bus(1'b1, 2'd3, 32'h0, a, r);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_00001) $display("FAIL nn_repend got %b exp 100001", {Ireq, gntInt}); else passed++;
        do_iack();
        bus(1'b1, 2'd3, 32'h0, a, r);
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b1_00010) $display("FAIL nn_next got %b exp 100010", {Ireq, gntInt}); else passed++;
        do_iack();
        bus(1'b1, 2'd3, 32'h0, a, r);
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        logic a; logic [31:0] r;
        @(negedge clk);
        stb = 1'b1; we = 1'b0; addr = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks[i] = ack;
        end
        stb = 1'b0;
        total++; if (acks !== 4'b0101) $display("FAIL b2b_acks got %b exp 0101", acks); else passed++;
        bus(1'b0, 2'd3, 32'h0, a, r);
        total++; if (r !== 32'h0) $display("FAIL eoi_read got %h exp 0", r); else passed++;
        bus(1'b1, 2'd3, 32'h0, a, r);
        total++; if ({a, Ireq, gntInt} !== 7'b1_0_00000) $display("FAIL eoi_idle got %b exp 1000000", {a, Ireq, gntInt}); else passed++;
    endtask

    task automatic test_reset_mid();
        logic a; logic [31:0] r;
        pulse(5'b00100);
        @(negedge clk);
        total++; if (Ireq !== 1'b1) $display("FAIL rst_pre got %b exp 1", Ireq); else passed++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++; if ({Ireq, gntInt} !== 6'b0) $display("FAIL rst_outs got %b exp 0", {Ireq, gntInt}); else passed++;
        do_iack();
        @(negedge clk);
        total++; if ({Ireq, gntInt} !== 6'b0) $display("FAIL rst_late_iack got %b exp 0", {Ireq, gntInt}); else passed++;
        bus(1'b0, 2'd1, 32'h0, a, r);
        total++; if (r !== 32'h0) $display("FAIL rst_pend got %h exp 0", r); else passed++;
        bus(1'b0, 2'd0, 32'h0, a, r);
        total++; if (r !== 32'h0) $display("FAIL rst_mask got %h exp 0", r); else passed++;
    endtask

    initial begin
        reset = 1'b0; irq_in = '0; Iack = 1'b0;
        stb = 1'b0; we = 1'b0; addr = '0; dat_i = '0;
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_withdraw();
        test_nonnested();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
